// File: rtl/corrupt_queue_ctrl_pkg.sv
// Shared sizing and pointer/occupancy types for the corrupt-flag queue controller.
package corrupt_queue_pkg;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int CW    = 8;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
endpackage

// File: rtl/corrupt_queue_ctrl_if.sv
// Enqueue/dequeue ready-valid handshake bundle; master is the channel logic, slave is the queue.
interface corrupt_queue_ctrl_if;
  logic enq_valid;
  logic enq_ready;
  logic enq_bits;
  logic deq_valid;
  logic deq_ready;
  logic deq_bits;

  modport master (
    output enq_valid, enq_bits, deq_ready,
    input  enq_ready, deq_valid, deq_bits
  );

  modport slave (
    input  enq_valid, enq_bits, deq_ready,
    output enq_ready, deq_valid, deq_bits
  );
endinterface

// File: rtl/corrupt_queue_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment, holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);
  always_ff @(posedge clock) begin
    if (!reset || clr) begin
      value <= '0;
    end else if (inc && (value != {W{1'b1}})) begin
      value <= value + W'(1);
    end
  end
endmodule

// File: rtl/corrupt_queue_ctrl.sv
// 8-entry corrupt-flag FIFO controller over external 8x1 storage; 1-cycle enq-to-deq, no bypass.
// enq_ready drops only when full (or in reset); deq side waits on deq_ready with head held.
module corrupt_queue_ctrl
  import corrupt_queue_pkg::*;
#(
  parameter int DEPTH = corrupt_queue_pkg::DEPTH,
  parameter int AW    = corrupt_queue_pkg::AW,
  parameter int CW    = corrupt_queue_pkg::CW
) (
  input  logic                  clock,
  input  logic                  reset,
  corrupt_queue_ctrl_if.slave   q,
  output logic [AW:0]           count,
  input  logic                  clear_cnt,
  output logic [CW-1:0]         corrupt_cnt,
  output logic [AW-1:0]         mem_W0_addr,
  output logic                  mem_W0_en,
  output logic                  mem_W0_data,
  output logic [AW-1:0]         mem_R0_addr,
  output logic                  mem_R0_en,
  input  logic                  mem_R0_data
);
  ptr_t head;
  ptr_t tail;
  logic maybe_full;
  logic ptr_match;
  logic empty;
  logic full;
  logic enq_fire;
  logic deq_fire;

  function automatic ptr_t bump(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign ptr_match = (head == tail);
  assign empty     = ptr_match & ~maybe_full;
  assign full      = ptr_match & maybe_full;
  assign count     = {full, ptr_t'(tail - head)};

  assign q.enq_ready = ~full & reset;
  assign q.deq_valid = ~empty;
  // Storage returns X while its read port is disabled, so gate it here.
  assign q.deq_bits  = q.deq_valid & mem_R0_data;

  assign enq_fire = q.enq_valid & q.enq_ready;
  assign deq_fire = q.deq_valid & q.deq_ready;

  assign mem_W0_en   = enq_fire;
  assign mem_W0_addr = tail;
  assign mem_W0_data = q.enq_bits;
  assign mem_R0_en   = q.deq_valid;
  assign mem_R0_addr = head;

  always_ff @(posedge clock) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      maybe_full <= 1'b0;
    end else begin
      if (enq_fire) tail <= bump(tail);
      if (deq_fire) head <= bump(head);
      // Equal pointers are ambiguous; the last unbalanced move decides full vs empty.
      if (enq_fire != deq_fire) maybe_full <= enq_fire;
    end
  end

  sat_counter #(.W(CW)) u_corrupt_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (deq_fire & q.deq_bits),
    .clr   (clear_cnt),
    .value (corrupt_cnt)
  );
endmodule
